// File: rtl/pkg_cpu.sv
// rtl/pkg_cpu.sv - spcpu bus encodings shared by the CPU and its memory responders
//
// Purpose: access-size encodings driven on data_acc_sz by the spcpu core.
// Ports:   none (package).

package pkg_cpu;

  localparam logic cpu_data_acc_sz_8  = 1'b0;
  localparam logic cpu_data_acc_sz_16 = 1'b1;

endpackage

// File: rtl/pkg_mem_resp.sv
// rtl/pkg_mem_resp.sv - types, defaults and helpers for the spcpu memory responder
//
// Purpose: responder FSM state type, default geometry, and the address range check.
// Ports:   none (package).

package pkg_mem_resp;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_SERVE = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  localparam int ADDR_W_DEF     = 16;
  localparam int DEPTH_LOG2_DEF = 10;
  localparam int ERR_CNT_W_DEF  = 8;

  // An address is in range when every bit above the RAM index is zero.
  // Taking the width as an argument keeps this usable for any DEPTH_LOG2.
  function automatic logic is_in_range(input logic [31:0] addr, input int depth_log2);
    return (addr >> depth_log2) == 32'd0;
  endfunction

endpackage

// File: rtl/mem_resp_byte_ram.sv
// rtl/mem_resp_byte_ram.sv - byte RAM with prioritised write mux and paired read ports
//
// Purpose: 2**DEPTH_LOG2 bytes of storage for the spcpu memory responder.
//          One synchronous write port, selected clear > load > bus.
//          Two combinational read ports returning the even and odd byte of a pair.
// Ports:
//   clk        in   1             write clock
//   clr_en     in   1             power-on clear write (data forced to 0)
//   clr_addr   in   DEPTH_LOG2    clear byte address
//   load_en    in   1             preload write
//   load_addr  in   DEPTH_LOG2    preload byte address
//   load_data  in   8             preload byte
//   bus_en     in   1             CPU 8-bit store
//   bus_addr   in   DEPTH_LOG2    CPU store byte address
//   bus_data   in   8             CPU store byte
//   rd_pair    in   DEPTH_LOG2-1  byte-pair index (byte address without bit 0)
//   rd_even    out  8             byte at {rd_pair, 0}
//   rd_odd     out  8             byte at {rd_pair, 1}

module mem_resp_byte_ram #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                    clk,
  input  logic                    clr_en,
  input  logic [DEPTH_LOG2-1:0]   clr_addr,
  input  logic                    load_en,
  input  logic [DEPTH_LOG2-1:0]   load_addr,
  input  logic [7:0]              load_data,
  input  logic                    bus_en,
  input  logic [DEPTH_LOG2-1:0]   bus_addr,
  input  logic [7:0]              bus_data,
  input  logic [DEPTH_LOG2-2:0]   rd_pair,
  output logic [7:0]              rd_even,
  output logic [7:0]              rd_odd
);

  logic [7:0] mem [2**DEPTH_LOG2];

  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] wr_addr;
  logic [7:0]            wr_data;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = 8'h00;
    if (clr_en) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
      wr_data = 8'h00;
    end else if (load_en) begin
      wr_en   = 1'b1;
      wr_addr = load_addr;
      wr_data = load_data;
    end else if (bus_en) begin
      wr_en   = 1'b1;
      wr_addr = bus_addr;
      wr_data = bus_data;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_even = mem[{rd_pair, 1'b0}];
  assign rd_odd  = mem[{rd_pair, 1'b1}];

endmodule

// File: rtl/spcpu_mem_responder.sv
// rtl/spcpu_mem_responder.sv - big-endian byte RAM responder for the spcpu data bus
//
// Purpose: answers spcpu data-bus requests one cycle after they are sampled,
//          clears the RAM after reset, accepts byte preloads, and counts bad accesses.
// Ports:
//   clk              in     1           single clock, all state on posedge
//   reset            in     1           synchronous, active-high
//   data_inout       inout  16          read data out when we=0; store data in when we=1
//   data_inout_addr  in     ADDR_W      byte address of the request
//   data_acc_sz      in     1           pkg_cpu::cpu_data_acc_sz_8 / _16
//   data_inout_we    in     1           0=read, 1=write
//   load_en          in     1           preload request
//   load_addr        in     DEPTH_LOG2  preload byte address
//   load_data        in     8           preload byte
//   ready            out    1           high only while serving the bus
//   bad_access       out    1           sticky error flag
//   bad_access_cnt   out    ERR_CNT_W   saturating bad-access count
//   err_clr          in     1           clears bad_access and bad_access_cnt

module spcpu_mem_responder
  import pkg_cpu::*;
  import pkg_mem_resp::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int ERR_CNT_W  = ERR_CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  inout  wire  [15:0]            data_inout,
  input  logic [ADDR_W-1:0]      data_inout_addr,
  input  logic                   data_acc_sz,
  input  logic                   data_inout_we,
  input  logic                   load_en,
  input  logic [DEPTH_LOG2-1:0]  load_addr,
  input  logic [7:0]             load_data,
  output logic                   ready,
  output logic                   bad_access,
  output logic [ERR_CNT_W-1:0]   bad_access_cnt,
  input  logic                   err_clr
);

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_LAST = '1;
  localparam logic [ERR_CNT_W-1:0]  CNT_ONE  = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_CNT_W-1:0]  CNT_MAX  = '1;

  state_t                state;
  state_t                state_nxt;
  logic [DEPTH_LOG2-1:0] clr_ptr;
  logic [15:0]           rd_data_q;
  logic [15:0]           rd_data_nxt;

  logic                  serving;
  logic                  in_range;
  logic                  is_8;
  logic [DEPTH_LOG2-1:0] addr_lo;
  logic                  bad_now;
  logic                  clr_wr;
  logic                  load_wr;
  logic                  bus_wr;
  logic [7:0]            rd_even;
  logic [7:0]            rd_odd;
  logic                  unused_store_hi;

  assign serving  = (state == ST_SERVE);
  assign in_range = is_in_range(32'(data_inout_addr), DEPTH_LOG2);
  assign is_8     = (data_acc_sz == cpu_data_acc_sz_8);
  assign addr_lo  = data_inout_addr[DEPTH_LOG2-1:0];
  assign ready    = serving;

  // Only the low byte of store data is ever written.
  assign unused_store_hi = ^data_inout[15:8];

  // Out of range, or a 16-bit store, is an error; nothing is counted outside ST_SERVE.
  assign bad_now = serving && (!in_range || (data_inout_we && !is_8));

  // Writes are suppressed during reset so a reset mid-load leaves no partial preload.
  assign clr_wr  = !reset && (state == ST_CLEAR);
  assign load_wr = !reset && (state == ST_LOAD) && load_en;
  assign bus_wr  = !reset && serving && data_inout_we && is_8 && in_range;

  mem_resp_byte_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk       (clk),
    .clr_en    (clr_wr),
    .clr_addr  (clr_ptr),
    .load_en   (load_wr),
    .load_addr (load_addr),
    .load_data (load_data),
    .bus_en    (bus_wr),
    .bus_addr  (addr_lo),
    .bus_data  (data_inout[7:0]),
    .rd_pair   (addr_lo[DEPTH_LOG2-1:1]),
    .rd_even   (rd_even),
    .rd_odd    (rd_odd)
  );

  always_comb begin
    state_nxt   = state;
    rd_data_nxt = 16'h0000;
    case (state)
      ST_CLEAR: begin
        if (clr_ptr == PTR_LAST) begin
          state_nxt = ST_SERVE;
        end
      end
      ST_SERVE: begin
        // The request of the cycle that raises load_en is still answered.
        if (load_en) begin
          state_nxt = ST_LOAD;
        end
        if (data_inout_we) begin
          rd_data_nxt = rd_data_q;
        end else if (in_range) begin
          if (is_8) begin
            rd_data_nxt = {8'h00, addr_lo[0] ? rd_odd : rd_even};
          end else begin
            // Big-endian pair: the even byte is the most significant.
            rd_data_nxt = {rd_even, rd_odd};
          end
        end
      end
      ST_LOAD: begin
        if (!load_en) begin
          state_nxt = ST_SERVE;
        end
      end
      default: begin
        state_nxt = ST_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_CLEAR;
      clr_ptr        <= '0;
      rd_data_q      <= 16'h0000;
      bad_access     <= 1'b0;
      bad_access_cnt <= '0;
    end else begin
      state     <= state_nxt;
      rd_data_q <= rd_data_nxt;
      if (state == ST_CLEAR) begin
        clr_ptr <= clr_ptr + PTR_ONE;
      end
      // A coincident err_clr clears the old history but the new error still counts.
      if (bad_now) begin
        bad_access <= 1'b1;
        if (err_clr) begin
          bad_access_cnt <= CNT_ONE;
        end else if (bad_access_cnt != CNT_MAX) begin
          bad_access_cnt <= bad_access_cnt + CNT_ONE;
        end
      end else if (err_clr) begin
        bad_access     <= 1'b0;
        bad_access_cnt <= '0;
      end
    end
  end

  assign data_inout = data_inout_we ? 16'hzzzz : rd_data_q;

endmodule

// File: tb/tb_spcpu_mem_responder.sv
// tb/tb_spcpu_mem_responder.sv - directed self-checking bench for spcpu_mem_responder

module tb_spcpu_mem_responder;
  import pkg_cpu::*;

  localparam logic SZ8  = cpu_data_acc_sz_8;
  localparam logic SZ16 = cpu_data_acc_sz_16;

  logic        clk = 1'b0;
  logic        reset;
  wire  [15:0] data_inout;
  logic [15:0] addr;
  logic        sz;
  logic        we;
  logic [15:0] wdata;
  logic        load_en;
  logic [9:0]  load_addr;
  logic [7:0]  load_data;
  logic        ready;
  logic        bad_access;
  logic [7:0]  cnt;
  logic        err_clr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // The bench drives store data only while we=1; the responder must then float.
  assign data_inout = we ? wdata : 16'hzzzz;

  spcpu_mem_responder dut (
    .clk             (clk),
    .reset           (reset),
    .data_inout      (data_inout),
    .data_inout_addr (addr),
    .data_acc_sz     (sz),
    .data_inout_we   (we),
    .load_en         (load_en),
    .load_addr       (load_addr),
    .load_data       (load_data),
    .ready           (ready),
    .bad_access      (bad_access),
    .bad_access_cnt  (cnt),
    .err_clr         (err_clr)
  );

  typedef struct {
    logic [15:0] a;
    logic        s;
    logic        w;
    logic [15:0] d;
    logic        ec;
    logic [15:0] exp_d;
    logic        exp_bad;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus(input logic [15:0] a, input logic s, input logic w,
                     input logic [15:0] d, input logic ec);
    @(negedge clk);
    addr    = a;
    sz      = s;
    we      = w;
    wdata   = d;
    err_clr = ec;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (n < 2000) begin
      @(posedge clk);
      #1;
      n++;
      if (ready) break;
    end
  endtask

  int n;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; addr = 16'h0; sz = SZ8; we = 1'b0; wdata = 16'h0;
    load_en = 1'b0; load_addr = 10'h0; load_data = 8'h0; err_clr = 1'b0;

    vecs[0]  = '{16'h0011, SZ16, 1'b0, 16'h0000, 1'b0, 16'hABCD, 1'b0, 8'd0};
    vecs[1]  = '{16'h0011, SZ8,  1'b0, 16'h0000, 1'b0, 16'h00CD, 1'b0, 8'd0};
    vecs[2]  = '{16'h0010, SZ8,  1'b0, 16'h0000, 1'b0, 16'h00AB, 1'b0, 8'd0};
    vecs[3]  = '{16'h0010, SZ16, 1'b0, 16'h0000, 1'b0, 16'hABCD, 1'b0, 8'd0};
    vecs[4]  = '{16'h0020, SZ8,  1'b1, 16'h005A, 1'b0, 16'h005A, 1'b0, 8'd0};
    vecs[5]  = '{16'h0020, SZ8,  1'b0, 16'h0000, 1'b0, 16'h005A, 1'b0, 8'd0};
    vecs[6]  = '{16'h0020, SZ16, 1'b0, 16'h0000, 1'b0, 16'h5A00, 1'b0, 8'd0};
    vecs[7]  = '{16'h0021, SZ8,  1'b1, 16'h1234, 1'b0, 16'h1234, 1'b0, 8'd0};
    vecs[8]  = '{16'h0021, SZ16, 1'b0, 16'h0000, 1'b0, 16'h5A34, 1'b0, 8'd0};
    vecs[9]  = '{16'h03FF, SZ8,  1'b1, 16'h0077, 1'b0, 16'h0077, 1'b0, 8'd0};
    vecs[10] = '{16'h03FE, SZ16, 1'b0, 16'h0000, 1'b0, 16'h0077, 1'b0, 8'd0};
    vecs[11] = '{16'h03FF, SZ8,  1'b0, 16'h0000, 1'b0, 16'h0077, 1'b0, 8'd0};
    vecs[12] = '{16'h0030, SZ16, 1'b1, 16'hBEEF, 1'b0, 16'hBEEF, 1'b1, 8'd1};
    vecs[13] = '{16'h0400, SZ8,  1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 8'd2};
    vecs[14] = '{16'h0030, SZ8,  1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 8'd2};
    vecs[15] = '{16'h8020, SZ8,  1'b1, 16'h0011, 1'b0, 16'h0011, 1'b1, 8'd3};
    vecs[16] = '{16'h0020, SZ8,  1'b0, 16'h0000, 1'b0, 16'h005A, 1'b1, 8'd3};
    vecs[17] = '{16'h0420, SZ8,  1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 8'd4};
    vecs[18] = '{16'h0010, SZ8,  1'b0, 16'h0000, 1'b1, 16'h00AB, 1'b0, 8'd0};

    // Reset state and clear duration.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", {15'h0, ready}, 16'h0000);
    chk("reset_bad", {15'h0, bad_access}, 16'h0000);
    chk("reset_cnt", {8'h0, cnt}, 16'h0000);
    chk("reset_data", data_inout, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    wait_ready(n);
    chk("clear_cycles", 16'(n), 16'd1024);

    bus(16'h0000, SZ16, 1'b0, 16'h0, 1'b0); chk("clr_rd_0000", data_inout, 16'h0000);
    bus(16'h03FF, SZ8,  1'b0, 16'h0, 1'b0); chk("clr_rd_03ff", data_inout, 16'h0000);
    bus(16'h0155, SZ16, 1'b0, 16'h0, 1'b0); chk("clr_rd_0155", data_inout, 16'h0000);

    // Preload 0x10=AB, 0x11=CD.
    @(negedge clk);
    load_en = 1'b1; load_addr = 10'h010; load_data = 8'hAB; addr = 16'h0; sz = SZ8;
    @(posedge clk); #1;
    chk("load_enter_ready", {15'h0, ready}, 16'h0000);
    @(negedge clk);
    @(posedge clk); #1;
    chk("load_rd_zero", data_inout, 16'h0000);
    @(negedge clk);
    load_addr = 10'h011; load_data = 8'hCD;
    @(posedge clk); #1;
    @(negedge clk);
    load_en = 1'b0;
    @(posedge clk); #1;
    chk("load_exit_ready", {15'h0, ready}, 16'h0001);

    for (int i = 0; i < 19; i++) begin
      bus(vecs[i].a, vecs[i].s, vecs[i].w, vecs[i].d, vecs[i].ec);
      chk($sformatf("vec%0d_data", i), data_inout, vecs[i].exp_d);
      chk($sformatf("vec%0d_bad", i), {15'h0, bad_access}, {15'h0, vecs[i].exp_bad});
      chk($sformatf("vec%0d_cnt", i), {8'h0, cnt}, {8'h0, vecs[i].exp_cnt});
    end

    // Counter saturation.
    for (int i = 0; i < 254; i++) bus(16'h0400, SZ8, 1'b0, 16'h0, 1'b0);
    chk("sat_254", {8'h0, cnt}, 16'h00FE);
    for (int i = 0; i < 46; i++) bus(16'h0400, SZ8, 1'b0, 16'h0, 1'b0);
    chk("sat_300", {8'h0, cnt}, 16'h00FF);
    chk("sat_bad", {15'h0, bad_access}, 16'h0001);
    bus(16'h0010, SZ8, 1'b0, 16'h0, 1'b1);
    chk("clr_cnt", {8'h0, cnt}, 16'h0000);
    chk("clr_bad", {15'h0, bad_access}, 16'h0000);

    // err_clr coinciding with a bad access.
    for (int i = 0; i < 3; i++) bus(16'h0400, SZ8, 1'b0, 16'h0, 1'b0);
    chk("pre_race_cnt", {8'h0, cnt}, 16'h0003);
    bus(16'h0400, SZ8, 1'b0, 16'h0, 1'b1);
    chk("race_cnt", {8'h0, cnt}, 16'h0001);
    chk("race_bad", {15'h0, bad_access}, 16'h0001);
    bus(16'h0010, SZ8, 1'b0, 16'h0, 1'b1);
    chk("race_clr_cnt", {8'h0, cnt}, 16'h0000);

    // Second load: entry request is serviced, bus stores and errors are ignored in ST_LOAD.
    @(negedge clk);
    load_en = 1'b1; load_addr = 10'h040; load_data = 8'h99;
    addr = 16'h0010; sz = SZ16; we = 1'b0; err_clr = 1'b0;
    @(posedge clk); #1;
    chk("load2_entry_rd", data_inout, 16'hABCD);
    @(negedge clk);
    addr = 16'h0020; sz = SZ8; we = 1'b1; wdata = 16'h00EE;
    @(posedge clk); #1;
    chk("load2_float", data_inout, 16'h00EE);
    chk("load2_ready", {15'h0, ready}, 16'h0000);
    @(negedge clk);
    load_addr = 10'h041; load_data = 8'h88;
    addr = 16'h0030; sz = SZ16; we = 1'b1; wdata = 16'hBEEF;
    @(posedge clk); #1;
    chk("load2_nobad", {15'h0, bad_access}, 16'h0000);
    chk("load2_nocnt", {8'h0, cnt}, 16'h0000);
    @(negedge clk);
    load_en = 1'b0; load_addr = 10'h042; load_data = 8'h77;
    addr = 16'h0040; sz = SZ8; we = 1'b0;
    @(posedge clk); #1;
    chk("load2_last_rd", data_inout, 16'h0000);
    chk("load2_exit_ready", {15'h0, ready}, 16'h0001);
    bus(16'h0040, SZ16, 1'b0, 16'h0, 1'b0); chk("load2_rd_40", data_inout, 16'h9988);
    bus(16'h0020, SZ8,  1'b0, 16'h0, 1'b0); chk("load2_drop_st", data_inout, 16'h005A);
    bus(16'h0042, SZ8,  1'b0, 16'h0, 1'b0); chk("load2_no_exit_wr", data_inout, 16'h0000);

    // Reset in the middle of a load restarts the clear.
    @(negedge clk);
    load_en = 1'b1; load_addr = 10'h050; load_data = 8'h66; addr = 16'h0; sz = SZ8;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midload_reset_ready", {15'h0, ready}, 16'h0000);
    @(negedge clk);
    reset = 1'b0; load_en = 1'b0;
    wait_ready(n);
    chk("reclear_cycles", 16'(n), 16'd1024);
    bus(16'h0050, SZ8,  1'b0, 16'h0, 1'b0); chk("reclr_rd_50", data_inout, 16'h0000);
    bus(16'h0040, SZ16, 1'b0, 16'h0, 1'b0); chk("reclr_rd_40", data_inout, 16'h0000);
    bus(16'h0010, SZ16, 1'b0, 16'h0, 1'b0); chk("reclr_rd_10", data_inout, 16'h0000);
    bus(16'h0020, SZ8,  1'b0, 16'h0, 1'b0); chk("reclr_rd_20", data_inout, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
